gate_vector_checker: RTL and testbench
======================================

// Module: gate_vector_checker
// PURPOSE
//  Self-checking exhaustive stimulus engine for N-input reduction gates.
//  Steps vec through all 2^N input patterns, waits SETTLE cycles per pattern, then compares dut_out to the
//  expected reduction selected by op. Sits beside the gate under test; summarises the run as pass, err_cnt
//  and the first failing vector.
// PARAMETERS
//  N       8  gate input width / vector width (1..16)
//  SETTLE  2  wait cycles per vector before sampling dut_out (>=1)
// PORTS
//  clk             in   1    single clock, rising edge
//  rst             in   1    asynchronous reset, active-high
//  start           in   1    begin run; sampled only in IDLE
//  abort           in   1    stop run; results frozen, no done pulse
//  op              in   2    00 OR, 01 AND, 10 XOR, 11 NOR; latched on start
//  dut_out         in   1    gate-under-test response
//  vec             out  N    current stimulus vector to DUT
//  busy            out  1    high from the cycle after start until DONE exits
//  done            out  1    one-cycle pulse at end of a completed run
//  pass            out  1    err_cnt==0 at completion; held until next start
//  err_cnt         out  N+1  mismatch count (max 2^N, never wraps)
//  first_fail_vec  out  N    vec value of the first mismatch in this run
//  first_fail_vld  out  1    first_fail_vec is valid
// BEHAVIOUR
//  - All outputs registered. Reset: vec=0, busy=0, done=0, pass=0, err_cnt=0, first_fail_vec=0,
//    first_fail_vld=0, FSM=IDLE, internal settle counter=0, latched op=00.
//  - FSM: IDLE -> SETTLE -> CHECK -> (SETTLE | DONE) -> IDLE.
//  - IDLE: on start=1 -> latch op; vec<=0; err_cnt<=0; pass<=0; first_fail_vld<=0; first_fail_vec<=0;
//    busy<=1; go SETTLE. start while busy is ignored.
//  - SETTLE: vec held stable; stays exactly SETTLE cycles, then CHECK.
//  - CHECK (1 cycle): exp = |vec, &vec, ^vec or ~|vec per latched op.
//    - If dut_out!=exp: err_cnt++; if !first_fail_vld, capture vec into first_fail_vec and set first_fail_vld.
//    - If vec==all-ones go DONE, else vec<=vec+1 and go SETTLE.
//  - Per vector: SETTLE+1 cycles. done rises exactly 2^N*(SETTLE+1) edges after the edge that sampled
//    start (N=2, SETTLE=1: 8 edges).
//  - DONE (1 cycle): done=1, pass=(err_cnt==0); next edge busy<=0, done<=0, IDLE.
//  - After a run, vec holds its last value (all-ones) until the next start.
//  - abort=1 in SETTLE/CHECK/DONE: next edge -> IDLE, busy<=0, done stays 0, pass stays 0;
//    err_cnt, first_fail_* and vec freeze. abort in IDLE has no effect. abort and start both high in IDLE:
//    abort wins and start is ignored.
//  - CHECK mismatch and abort on the same cycle: abort wins, and no count update occurs.
//  - rst during a run: immediate return to reset values; no done pulse.
//  - err_cnt is N+1 bits, so 2^N mismatches fit without saturation logic.
// TESTING
//  1. N=8, SETTLE=2, op=OR, ideal OR DUT; start -> done after 768 edges; pass=1, err_cnt=0, first_fail_vld=0.
//  2. op=OR, DUT stuck-at-0 -> err_cnt=255, first_fail_vec=8'h01, first_fail_vld=1, pass=0.
//  3. op=XOR, DUT stuck-at-1 -> err_cnt=128, first_fail_vec=8'h00; op=AND with ideal AND DUT -> pass=1.
//  4. Pulse start again mid-run -> ignored; done timing unchanged at 768 edges from the first start.
//  5. abort while vec=8'h40 -> busy=0 next edge, no done, vec frozen at 8'h40; a new start fully restarts
//     and clears results.
//  6. rst asserted mid-run (asynchronously, between edges) -> all outputs reset at once; a later start
//     completes normally.

Source files
------------

// File: rtl/gate_vector_checker.sv
// Exhaustive stimulus engine for an N-input reduction gate: walks vec through every
// pattern, samples dut_out after SETTLE cycles and tallies mismatches against op.
module gate_vector_checker #(
  parameter int N      = 8,
  parameter int SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [1:0]   op,
  input  logic         dut_out,
  output logic [N-1:0] vec,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_cnt,
  output logic [N-1:0] first_fail_vec,
  output logic         first_fail_vld
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int EW = N + 1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t        r_state;
  logic [1:0]    r_op;
  logic [CW-1:0] r_cnt;

  logic          w_exp;
  logic          w_mis;
  logic          w_last;
  logic [N:0]    w_err_nxt;

  always_comb begin
    w_exp = 1'b0;
    case (r_op)
      2'b00:   w_exp = |vec;
      2'b01:   w_exp = &vec;
      2'b10:   w_exp = ^vec;
      default: w_exp = ~|vec;
    endcase
  end

  assign w_mis     = (dut_out != w_exp);
  assign w_last    = &vec;
  assign w_err_nxt = err_cnt + EW'(w_mis);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_op           <= 2'b00;
      r_cnt          <= '0;
      vec            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_fail_vec <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_op           <= op;
            vec            <= '0;
            err_cnt        <= '0;
            pass           <= 1'b0;
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
            busy           <= 1'b1;
            r_cnt          <= '0;
            r_state        <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            busy    <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (r_cnt == CW'(SETTLE - 1)) begin
            r_cnt   <= '0;
            r_state <= S_CHECK;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_CHECK: begin
          // Abort takes priority over any count update from this vector.
          if (abort) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            if (w_mis) begin
              err_cnt <= w_err_nxt;
              if (!first_fail_vld) begin
                first_fail_vec <= vec;
                first_fail_vld <= 1'b1;
              end
            end
            if (w_last) begin
              done    <= 1'b1;
              pass    <= (w_err_nxt == '0);
              r_state <= S_DONE;
            end else begin
              vec     <= vec + N'(1);
              r_state <= S_SETTLE;
            end
          end
        end
        default: begin
          // An abort landing on the done cycle withdraws the verdict.
          if (abort) begin
            pass <= 1'b0;
          end
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench for gate_vector_checker with a behavioural gate model and a
// queue of expected run summaries popped when each done pulse appears.
module tb_gate_vector_checker;

  localparam int N       = 8;
  localparam int SETTLE  = 2;
  localparam int PER_RUN = (1 << N) * (SETTLE + 1);

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic [1:0]   op;
  logic         dut_out;
  logic [N-1:0] vec;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N:0]   err_cnt;
  logic [N-1:0] first_fail_vec;
  logic         first_fail_vld;

  // 0 ideal OR, 1 ideal AND, 2 ideal XOR, 3 ideal NOR, 4 stuck-at-0, 5 stuck-at-1
  int mode;

  typedef struct {
    logic         pass;
    int           err;
    logic [N-1:0] ffv;
    logic         fvld;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  gate_vector_checker #(.N(N), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .op(op), .dut_out(dut_out),
    .vec(vec), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_fail_vec(first_fail_vec), .first_fail_vld(first_fail_vld)
  );

  always #5 clk = ~clk;

  function automatic logic ref_red(input logic [1:0] o, input logic [N-1:0] v);
    case (o)
      2'b00:   return |v;
      2'b01:   return &v;
      2'b10:   return ^v;
      default: return ~|v;
    endcase
  endfunction

  function automatic logic gate_model(input int m, input logic [N-1:0] v);
    case (m)
      0:       return |v;
      1:       return &v;
      2:       return ^v;
      3:       return ~|v;
      4:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  assign dut_out = gate_model(mode, vec);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_expected(input logic [1:0] o, input int m);
    exp_t e;
    logic [N-1:0] v;
    e.err  = 0;
    e.ffv  = '0;
    e.fvld = 1'b0;
    for (int i = 0; i < (1 << N); i++) begin
      v = N'(i);
      if (gate_model(m, v) != ref_red(o, v)) begin
        if (!e.fvld) begin
          e.ffv  = v;
          e.fvld = 1'b1;
        end
        e.err++;
      end
    end
    e.pass = (e.err == 0);
    q.push_back(e);
  endtask

  task automatic pulse_start(input logic [1:0] o);
    @(negedge clk);
    op    = o;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_vec", 32'(vec), 32'd0);
    chk("start_err", 32'(err_cnt), 32'd0);
    chk("start_fvld", 32'(first_fail_vld), 32'd0);
  endtask

  task automatic run(input string tag, input logic [1:0] o, input int m, input bit glitch);
    int   e;
    bit   seen;
    exp_t x;
    mode = m;
    push_expected(o, m);
    pulse_start(o);
    e    = 0;
    seen = 1'b0;
    while (!seen && e < PER_RUN + 50) begin
      @(posedge clk);
      #1;
      e++;
      start = glitch && (e == 100);
      if (glitch && e == 100) op = ~o;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    op    = o;
    x     = q.pop_front();
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(e), 32'(PER_RUN));
    chk({tag, "_pass"}, 32'(pass), 32'(x.pass));
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(x.err));
    chk({tag, "_ffv"}, 32'(first_fail_vec), 32'(x.ffv));
    chk({tag, "_fvld"}, 32'(first_fail_vld), 32'(x.fvld));
    @(posedge clk);
    #1;
    chk({tag, "_done_drop"}, 32'(done), 32'd0);
    chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
    chk({tag, "_vec_hold"}, 32'(vec), 32'hFF);
    chk({tag, "_pass_hold"}, 32'(pass), 32'(x.pass));
  endtask

  initial begin
    int  e;
    bit  seen;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    op    = 2'b00;
    mode  = 0;
    #12;
    chk("rst_vec", 32'(vec), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    chk("rst_ffv", 32'(first_fail_vec), 32'd0);
    chk("rst_fvld", 32'(first_fail_vld), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run("or_ideal", 2'b00, 0, 1'b0);
    run("or_stuck0", 2'b00, 4, 1'b0);
    run("xor_stuck1", 2'b10, 5, 1'b0);
    run("and_ideal", 2'b01, 1, 1'b0);
    run("nor_glitch", 2'b11, 3, 1'b1);

    // Abort while vec = 8'h40 against a stuck-at-0 OR gate.
    mode = 4;
    pulse_start(2'b00);
    e = 0;
    while (vec != 8'h40 && e < PER_RUN) begin
      @(posedge clk);
      #1;
      e++;
    end
    chk("abort_reach40", 32'(vec), 32'h40);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_vec", 32'(vec), 32'h40);
    chk("abort_err", 32'(err_cnt), 32'd63);
    chk("abort_ffv", 32'(first_fail_vec), 32'h01);
    chk("abort_fvld", 32'(first_fail_vld), 32'd1);
    chk("abort_pass", 32'(pass), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    chk("abort_vec_frozen", 32'(vec), 32'h40);

    // abort and start together in IDLE: abort wins.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_busy", 32'(busy), 32'd0);
    chk("abort_start_err", 32'(err_cnt), 32'd63);

    run("restart_or", 2'b00, 0, 1'b0);

    // Asynchronous reset between edges mid-run.
    mode = 4;
    pulse_start(2'b00);
    repeat (100) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_vec", 32'(vec), 32'd0);
    chk("arst_err", 32'(err_cnt), 32'd0);
    chk("arst_fvld", 32'(first_fail_vld), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run("post_rst_xor", 2'b10, 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
